stream_demux_1xn: RTL and testbench
===================================

// Module: stream_demux_1xn
// PURPOSE
//  Parametrised, registered 1-to-N stream demultiplexer. It is the sequential successor of the
//  structural 1x8 demux: it adds N channels, DW-bit data, valid/ready handshakes, packet lock
//  and a broadcast mode. It routes one upstream stream to N independent consumers, each
//  with its own backpressure.
// PARAMETERS
//  N_CH   8   number of output channels (>=2)
//  DW     8   data width in bits
//  SEL_W  $clog2(N_CH)   localparam, derived; not overridable
// PORTS
//  clk       in   1         single clock, rising edge
//  rst_n     in   1         asynchronous, active-low reset
//  s_valid   in   1         upstream beat valid
//  s_ready   out  1         upstream beat accepted when s_valid&s_ready
//  s_data    in   DW        upstream data
//  s_sel     in   SEL_W     target channel; sampled on the first beat of a packet only
//  s_bcast   in   1         1 = copy the packet to all channels; sampled like s_sel
//  s_last    in   1         final beat of a packet
//  m_valid   out  N_CH      per-channel valid
//  m_ready   in   N_CH      per-channel ready
//  m_data    out  N_CH*DW   channel k occupies bits [k*DW +: DW]
//  m_last    out  N_CH      per-channel last
//  err_sel   out  1         one-cycle pulse when a packet head carries s_sel >= N_CH (non-broadcast)
// BEHAVIOUR
//  Reset (async assert, sync-deasserted use): m_valid=0, m_data=0, m_last=0, err_sel=0, FSM=IDLE.
//   s_ready=0 while rst_n=0.
//  Each channel has one output slot (valid/data/last register). The slot can load when it is
//   empty or m_ready[k]=1 in the same cycle (full-throughput pass-through).
//  Latency: a beat accepted in cycle t appears on m_* in cycle t+1. Sustained rate is 1 beat/clk
//   while the target channel keeps m_ready=1.
//  Target set T: IDLE uses s_sel/s_bcast; LOCK/DROP use the latched values.
//   Unicast: T={sel}. Broadcast: T=all.
//  s_ready = AND over k in T of can_load[k]. Broadcast loads all slots in the same cycle only;
//   it never splits a beat. DROP: s_ready=1.
//  FSM (states in package):
//   IDLE: on an accepted beat with last=0 -> LOCK (latch sel,bcast) if sel valid or bcast,
//         otherwise -> DROP. An accepted beat with last=1 stays in IDLE (single-beat packet).
//   LOCK: s_sel/s_bcast are ignored. An accepted beat with last=1 -> IDLE.
//   DROP: beats are accepted and discarded; no m_valid. An accepted beat with last=1 -> IDLE.
//  Invalid sel (>=N_CH, bcast=0) on a head beat: the beat is consumed, err_sel pulses in the
//   next cycle, nothing is written. If N_CH is a power of 2, no sel value is invalid.
//  m_* are held stable while m_valid[k]=1 and m_ready[k]=0 (AXI-style; no retraction).
//  m_data of an empty slot keeps its last value. Only m_valid qualifies the data.
//  Reset mid-packet: in-flight slots are cleared, the FSM goes to IDLE, and the next beat is
//   treated as a head.
//  s_valid=0: no state change. m_ready of channels outside T never affects s_ready.
// STRUCTURE
//  Package stream_demux_pkg: typedef enum {IDLE, LOCK, DROP} demux_state_e; function to
//   compute the target-mask one-hot from sel/bcast.
//  Sub-module demux_out_slot (#DW): a one-entry register with load/valid/ready/last.
//   It is instantiated N_CH times with a generate loop.
//  The top holds the FSM, the sel/bcast latch, the target mask, s_ready and err_sel.
// TESTING
//  1 Unicast sweep, N_CH=8, DW=8: single-beat packets sel=0..7, data=8'hA0+sel, all m_ready=1
//    -> m_valid one-hot at bit sel next cycle, m_data[sel]=8'hA0+sel, m_last=1.
//  2 Packet lock: 3-beat packet with sel=2 on the head, then s_sel=5 on beats 2-3
//    -> all beats appear on ch2; ch5 stays idle; FSM returns to IDLE after last.
//  3 Backpressure: stream 4 beats to ch3 with m_ready[3]=0 for 3 cycles
//    -> s_ready=0 after the slot fills; m_data[3] holds stable; no beat lost or duplicated.
//  4 Broadcast: s_bcast=1, data=8'h5A, m_ready[6]=0
//    -> s_ready=0 until m_ready[6]=1, then all 8 channels show 8'h5A in the same cycle.
//  5 Invalid sel: N_CH=6, head sel=7, 2-beat packet, then a valid packet to sel=1
//    -> err_sel pulses once; no m_valid during the drop; the ch1 packet is delivered.
//  6 Reset mid-packet: assert rst_n=0 during beat 2 of a LOCK packet
//    -> m_valid=0 immediately; after release, a head with sel=4 routes to ch4.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
package stream_demux_pkg;

    // Upper bound on channel count supported by the target-mask helper.
    localparam int unsigned MAX_CH = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        DROP = 2'd2
    } demux_state_e;

    // Target mask: one bit per channel; all live channels for broadcast,
    // otherwise only the selected channel (zero when sel is out of range).
    function automatic logic [MAX_CH-1:0] target_mask(
        input int unsigned sel,
        input logic        bcast,
        input int unsigned n_ch
    );
        logic [MAX_CH-1:0] mask;
        mask = '0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            mask[k] = (k < n_ch) && (bcast || (k == sel));
        end
        return mask;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register (valid/data/last) for a single demux channel.
module demux_out_slot #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    input  logic          i_ready,
    output logic          o_can_load,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_last
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_last;

    // Slot accepts a new beat when empty or draining in the same cycle.
    assign o_can_load = !r_valid || i_ready;

    // Slot register; data and last only change on a load so they stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demultiplexer with packet lock, broadcast and bad-select drop.
module stream_demux_1xn
    import stream_demux_pkg::*;
#(
    parameter  int unsigned N_CH  = 8,
    parameter  int unsigned DW    = 8,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DW-1:0]      s_data,
    input  logic [SEL_W-1:0]   s_sel,
    input  logic               s_bcast,
    input  logic               s_last,
    output logic [N_CH-1:0]    m_valid,
    input  logic [N_CH-1:0]    m_ready,
    output logic [N_CH*DW-1:0] m_data,
    output logic [N_CH-1:0]    m_last,
    output logic               err_sel
);

    demux_state_e     r_state;
    demux_state_e     w_state_nxt;
    logic [SEL_W-1:0] r_sel;
    logic             r_bcast;
    logic             r_err;

    logic [SEL_W-1:0] w_sel;
    logic             w_bcast;
    logic             w_sel_ok;
    logic             w_drop;
    logic             w_accept;
    logic [N_CH-1:0]  w_mask;
    logic [N_CH-1:0]  w_can_load;
    logic [N_CH-1:0]  w_load;

    // Routing source: live inputs on a packet head, latched values mid-packet.
    assign w_sel    = (r_state == IDLE) ? s_sel   : r_sel;
    assign w_bcast  = (r_state == IDLE) ? s_bcast : r_bcast;
    assign w_sel_ok = w_bcast || (32'(w_sel) < N_CH);
    assign w_mask   = N_CH'(target_mask(32'(w_sel), w_bcast, N_CH));

    // Dropped beats are swallowed without touching any slot.
    assign w_drop   = (r_state == DROP) || ((r_state == IDLE) && !w_sel_ok);

    // Ready only if every targeted slot can load this cycle; broadcast never splits a beat.
    assign s_ready  = rst_n && (w_drop || (&(w_can_load | ~w_mask)));
    assign w_accept = s_valid && s_ready;
    assign w_load   = (w_accept && !w_drop) ? w_mask : '0;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: heads open LOCK or DROP, last beats return to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !s_last) begin
                    w_state_nxt = w_sel_ok ? LOCK : DROP;
                end
            end
            LOCK, DROP: begin
                if (w_accept && s_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Latch the head routing and flag a dropped head for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel   <= '0;
            r_bcast <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_accept && (r_state == IDLE) && !w_sel_ok;
            if (w_accept && (r_state == IDLE)) begin
                r_sel   <= s_sel;
                r_bcast <= s_bcast;
            end
        end
    end

    assign err_sel = r_err;

    // One output slot per channel.
    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        demux_out_slot #(
            .DW (DW)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_load     (w_load[k]),
            .i_data     (s_data),
            .i_last     (s_last),
            .i_ready    (m_ready[k]),
            .o_can_load (w_can_load[k]),
            .o_valid    (m_valid[k]),
            .o_data     (m_data[k*DW +: DW]),
            .o_last     (m_last[k])
        );
    end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Scoreboard bench for stream_demux_1xn: an 8-channel and a 6-channel instance.
module tb_stream_demux_1xn;

    logic        clk;
    logic        rst_n;

    logic        s_valid8, s_ready8, s_bcast8, s_last8, err8;
    logic [7:0]  s_data8;
    logic [2:0]  s_sel8;
    logic [7:0]  m_valid8, m_ready8, m_last8;
    logic [63:0] m_data8;

    logic        s_valid6, s_ready6, s_bcast6, s_last6, err6;
    logic [7:0]  s_data6;
    logic [2:0]  s_sel6;
    logic [5:0]  m_valid6, m_ready6, m_last6;
    logic [47:0] m_data6;

    int n_checks = 0;
    int n_fail   = 0;
    int err8_cnt = 0;
    int err6_cnt = 0;

    logic [8:0] q8 [8][$];
    logic [8:0] q6 [6][$];

    stream_demux_1xn #(.N_CH(8), .DW(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8), .s_sel(s_sel8),
        .s_bcast(s_bcast8), .s_last(s_last8),
        .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8), .m_last(m_last8),
        .err_sel(err8)
    );

    stream_demux_1xn #(.N_CH(6), .DW(8)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid6), .s_ready(s_ready6), .s_data(s_data6), .s_sel(s_sel6),
        .s_bcast(s_bcast6), .s_last(s_last6),
        .m_valid(m_valid6), .m_ready(m_ready6), .m_data(m_data6), .m_last(m_last6),
        .err_sel(err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed output handshake is popped and compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err8) err8_cnt++;
            if (err6) err6_cnt++;
            for (int k = 0; k < 8; k++) begin
                if (m_valid8[k] && m_ready8[k]) begin
                    if (q8[k].size() == 0) begin
                        chk($sformatf("ch8_%0d_unexpected", k), {55'd0, m_last8[k], m_data8[k*8 +: 8]}, 64'hFFFF);
                    end else begin
                        chk($sformatf("ch8_%0d_beat", k), {55'd0, m_last8[k], m_data8[k*8 +: 8]},
                            {55'd0, q8[k].pop_front()});
                    end
                end
            end
            for (int k = 0; k < 6; k++) begin
                if (m_valid6[k] && m_ready6[k]) begin
                    if (q6[k].size() == 0) begin
                        chk($sformatf("ch6_%0d_unexpected", k), {55'd0, m_last6[k], m_data6[k*8 +: 8]}, 64'hFFFF);
                    end else begin
                        chk($sformatf("ch6_%0d_beat", k), {55'd0, m_last6[k], m_data6[k*8 +: 8]},
                            {55'd0, q6[k].pop_front()});
                    end
                end
            end
        end
    end

    // Present one beat (called just after a rising edge), wait for acceptance, queue expectations.
    task automatic send(input bit use6, input logic [7:0] d, input logic [2:0] sel,
                        input logic bc, input logic last, input logic [7:0] emask);
        bit ok;
        ok = 1'b0;
        if (use6) begin
            s_valid6 = 1'b1; s_data6 = d; s_sel6 = sel; s_bcast6 = bc; s_last6 = last;
        end else begin
            s_valid8 = 1'b1; s_data8 = d; s_sel8 = sel; s_bcast8 = bc; s_last8 = last;
        end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = use6 ? s_ready6 : s_ready8;
        end
        chk($sformatf("accept_%0h", d), {63'd0, ok}, 64'd1);
        if (ok) begin
            for (int k = 0; k < 8; k++) begin
                if (emask[k]) begin
                    if (use6) begin
                        if (k < 6) q6[k].push_back({last, d});
                    end else begin
                        q8[k].push_back({last, d});
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        s_valid8 = 1'b0;
        s_valid6 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        s_valid8 = 1'b1; s_data8 = '0; s_sel8 = '0; s_bcast8 = 1'b0; s_last8 = 1'b0;
        s_valid6 = 1'b0; s_data6 = '0; s_sel6 = '0; s_bcast6 = 1'b0; s_last6 = 1'b0;
        m_ready8 = 8'hFF;
        m_ready6 = 6'h3F;

        // Reset state
        #12;
        chk("rst_m_valid8", 64'(m_valid8), 64'd0);
        chk("rst_m_data8",  m_data8, 64'd0);
        chk("rst_m_last8",  64'(m_last8), 64'd0);
        chk("rst_err8",     64'(err8), 64'd0);
        chk("rst_s_ready8", 64'(s_ready8), 64'd0);
        chk("rst_m_valid6", 64'(m_valid6), 64'd0);
        s_valid8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: unicast sweep
        for (int s = 0; s < 8; s++) begin
            send(1'b0, 8'hA0 + 8'(s), 3'(s), 1'b0, 1'b1, 8'h01 << s);
            chk($sformatf("sweep_valid_%0d", s), 64'(m_valid8), 64'(8'h01 << s));
            chk($sformatf("sweep_data_%0d", s), 64'(m_data8[s*8 +: 8]), 64'(8'hA0 + 8'(s)));
        end

        // 2: packet lock; later beats carry sel=5 but stay on ch2, then ch5 head proves IDLE
        send(1'b0, 8'h21, 3'd2, 1'b0, 1'b0, 8'h04);
        send(1'b0, 8'h22, 3'd5, 1'b0, 1'b0, 8'h04);
        chk("lock_valid_b2", 64'(m_valid8), 64'h04);
        send(1'b0, 8'h23, 3'd5, 1'b0, 1'b1, 8'h04);
        chk("lock_valid_b3", 64'(m_valid8), 64'h04);
        send(1'b0, 8'h55, 3'd5, 1'b0, 1'b1, 8'h20);
        chk("lock_after_idle", 64'(m_valid8), 64'h20);

        // 3: backpressure on ch3
        m_ready8 = 8'hF7;
        send(1'b0, 8'h30, 3'd3, 1'b0, 1'b0, 8'h08);
        s_valid8 = 1'b1; s_data8 = 8'h31; s_sel8 = 3'd3; s_last8 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp_s_ready_%0d", c), 64'(s_ready8), 64'd0);
            chk($sformatf("bp_hold_%0d", c), 64'(m_data8[24 +: 8]), 64'h30);
            chk($sformatf("bp_valid_%0d", c), 64'(m_valid8[3]), 64'd1);
            @(posedge clk);
            #1;
        end
        m_ready8 = 8'hFF;
        send(1'b0, 8'h31, 3'd3, 1'b0, 1'b0, 8'h08);
        send(1'b0, 8'h32, 3'd3, 1'b0, 1'b0, 8'h08);
        send(1'b0, 8'h33, 3'd3, 1'b0, 1'b1, 8'h08);

        // 4: broadcast blocked by a full ch6 slot
        m_ready8 = 8'hBF;
        send(1'b0, 8'h66, 3'd6, 1'b0, 1'b1, 8'h40);
        s_valid8 = 1'b1; s_data8 = 8'h5A; s_sel8 = 3'd0; s_bcast8 = 1'b1; s_last8 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("bc_s_ready_%0d", c), 64'(s_ready8), 64'd0);
            @(posedge clk);
            #1;
        end
        m_ready8 = 8'hFF;
        send(1'b0, 8'h5A, 3'd0, 1'b1, 1'b1, 8'hFF);
        chk("bc_all_valid", 64'(m_valid8), 64'hFF);
        chk("bc_all_data", m_data8, 64'h5A5A5A5A5A5A5A5A);
        s_bcast8 = 1'b0;

        // 5: invalid select on the 6-channel instance
        send(1'b1, 8'h71, 3'd7, 1'b0, 1'b0, 8'h00);
        chk("inv_err_pulse", 64'(err6), 64'd1);
        chk("inv_no_valid_b1", 64'(m_valid6), 64'd0);
        send(1'b1, 8'h72, 3'd1, 1'b0, 1'b1, 8'h00);
        chk("inv_err_clear", 64'(err6), 64'd0);
        chk("inv_no_valid_b2", 64'(m_valid6), 64'd0);
        send(1'b1, 8'h11, 3'd1, 1'b0, 1'b1, 8'h02);
        chk("inv_next_valid", 64'(m_valid6), 64'h02);
        chk("inv_next_data", 64'(m_data6[8 +: 8]), 64'h11);

        // 6: reset in the middle of a locked packet
        m_ready8 = 8'h00;
        send(1'b0, 8'h61, 3'd1, 1'b0, 1'b0, 8'h00);
        s_valid8 = 1'b1; s_data8 = 8'h62; s_sel8 = 3'd1; s_last8 = 1'b0;
        @(negedge clk);
        chk("mid_stall", 64'(s_ready8), 64'd0);
        chk("mid_slot_full", 64'(m_valid8), 64'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_valid8), 64'd0);
        chk("mid_rst_ready", 64'(s_ready8), 64'd0);
        s_valid8 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ready8 = 8'hFF;
        @(posedge clk);
        #1;
        send(1'b0, 8'h44, 3'd4, 1'b0, 1'b0, 8'h10);
        chk("post_rst_head", 64'(m_valid8), 64'h10);
        send(1'b0, 8'h45, 3'd0, 1'b0, 1'b1, 8'h10);
        chk("post_rst_tail", 64'(m_valid8), 64'h10);

        // Drain and final accounting
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 8; k++) chk($sformatf("q8_%0d_left", k), 64'(q8[k].size()), 64'd0);
        for (int k = 0; k < 6; k++) chk($sformatf("q6_%0d_left", k), 64'(q6[k].size()), 64'd0);
        chk("err6_count", 64'(err6_cnt), 64'd1);
        chk("err8_count", 64'(err8_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
